// File: rtl/audio_pkg.sv
// Shared types and constants for the microphone capture path.
package audio_pkg;

    localparam int AUDIO_LEN_DEFAULT = 19200;
    localparam int SAMPLE_RATE_HZ    = 12000;

    typedef logic signed [7:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RECORDING,
        DONE
    } rec_state_t;

    // 9-bit magnitude so that -128 maps to 128 instead of wrapping
    function automatic logic [8:0] magnitude(input sample_t s);
        logic signed [8:0] w;
        w = {s[7], s};
        return s[7] ? 9'(-w) : 9'(w);
    endfunction

endpackage

// File: rtl/xilinx_simple_dual_port_1_clock_ram.sv
// Simple dual-port single-clock block RAM: port A writes, port B reads.
module xilinx_simple_dual_port_1_clock_ram #(
    parameter int RAM_WIDTH       = 8,
    parameter int RAM_DEPTH       = 65536,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         enb,
    input  logic                         rstb,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    // Read-first: a same-cycle read of a written address sees the old word
    always_ff @(posedge clka) begin
        if (wea)
            bram[addra] <= dina;
        if (enb)
            ram_data <= bram[addrb];
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_reg
            assign doutb = ram_data;
        end else begin : g_out_reg
            always_ff @(posedge clka) begin
                if (rstb)
                    doutb <= '0;
                else if (regceb)
                    doutb <= ram_data;
            end
        end
    endgenerate

endmodule

// File: rtl/audio_recorder.sv
// Records strobed mic samples into BRAM with an optional amplitude trigger;
// a second BRAM port serves readback.
module audio_recorder
    import audio_pkg::*;
#(
    parameter int AUDIO_LEN  = AUDIO_LEN_DEFAULT,
    parameter int RAM_DEPTH  = 65536,
    parameter bit TRIGGER_EN = 1'b0,
    parameter int THRESHOLD  = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_record,
    input  logic        stop_record,
    input  logic        signal_12khz,
    input  logic [7:0]  mic_in,
    input  logic [15:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        recording,
    output logic        record_done,
    output logic [15:0] rec_len
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(AUDIO_LEN - 1);
    localparam logic [8:0] THR = 9'(THRESHOLD);

    rec_state_t state, state_n;
    logic [AW-1:0] wr_count, count_n;
    logic [15:0] len_n;
    logic done_n;
    logic rec_n;
    logic we;
    logic [AW-1:0] waddr;
    logic loud;

    assign loud = magnitude(sample_t'(mic_in)) >= THR;

    always_comb begin
        state_n = state;
        count_n = wr_count;
        len_n   = rec_len;
        done_n  = 1'b0;
        we      = 1'b0;
        waddr   = wr_count;
        unique case (state)
            IDLE, DONE: begin
                if (start_record) begin
                    count_n = '0;
                    state_n = TRIGGER_EN ? ARMED : RECORDING;
                end
            end
            ARMED: begin
                if (stop_record) begin
                    state_n = IDLE;
                end else if (signal_12khz && loud) begin
                    we      = 1'b1;
                    waddr   = '0;
                    count_n = AW'(1);
                    state_n = RECORDING;
                    if (LAST == '0) begin
                        state_n = DONE;
                        len_n   = 16'(AUDIO_LEN);
                        done_n  = 1'b1;
                    end
                end
            end
            RECORDING: begin
                if (signal_12khz) begin
                    we      = 1'b1;
                    count_n = wr_count + AW'(1);
                end
                if (we && wr_count == LAST) begin
                    state_n = DONE;
                    len_n   = 16'(AUDIO_LEN);
                    done_n  = 1'b1;
                end else if (stop_record) begin
                    state_n = DONE;
                    len_n   = 16'(count_n);
                    done_n  = 1'b1;
                end
            end
        endcase
        rec_n = (state_n == ARMED) || (state_n == RECORDING);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            wr_count    <= '0;
            rec_len     <= '0;
            recording   <= 1'b0;
            record_done <= 1'b0;
        end else begin
            state       <= state_n;
            wr_count    <= count_n;
            rec_len     <= len_n;
            recording   <= rec_n;
            record_done <= done_n;
        end
    end

    xilinx_simple_dual_port_1_clock_ram #(
        .RAM_WIDTH      (8),
        .RAM_DEPTH      (RAM_DEPTH),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE")
    ) u_ram (
        .addra (waddr),
        .addrb (rd_addr[AW-1:0]),
        .dina  (mic_in),
        .clka  (clk_in),
        .wea   (we),
        .enb   (1'b1),
        .rstb  (rst_in),
        .regceb(1'b1),
        .doutb (rd_data)
    );

endmodule

// File: tb/tb_audio_recorder.sv
// Scoreboard bench: three recorders (free-run, trigger 16, trigger 128)
// share one stimulus bus; each scenario checks the relevant instance.
module tb_audio_recorder;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_record = 1'b0;
    logic        stop_record = 1'b0;
    logic        strobe = 1'b0;
    logic [7:0]  mic = '0;
    logic [15:0] rd_addr = '0;

    logic [7:0]  rdw [3];
    logic        recw [3];
    logic        donew [3];
    logic [15:0] lenw [3];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt [3];

    sample_t exq [$];
    sample_t sb [$];

    always #5 clk = ~clk;

    audio_recorder #(
        .AUDIO_LEN(8), .RAM_DEPTH(65536), .TRIGGER_EN(1'b0), .THRESHOLD(16)
    ) dut0 (
        .clk_in(clk), .rst_in(rst), .start_record(start_record),
        .stop_record(stop_record), .signal_12khz(strobe), .mic_in(mic),
        .rd_addr(rd_addr), .rd_data(rdw[0]), .recording(recw[0]),
        .record_done(donew[0]), .rec_len(lenw[0])
    );

    audio_recorder #(
        .AUDIO_LEN(8), .RAM_DEPTH(65536), .TRIGGER_EN(1'b1), .THRESHOLD(16)
    ) dut1 (
        .clk_in(clk), .rst_in(rst), .start_record(start_record),
        .stop_record(stop_record), .signal_12khz(strobe), .mic_in(mic),
        .rd_addr(rd_addr), .rd_data(rdw[1]), .recording(recw[1]),
        .record_done(donew[1]), .rec_len(lenw[1])
    );

    audio_recorder #(
        .AUDIO_LEN(8), .RAM_DEPTH(65536), .TRIGGER_EN(1'b1), .THRESHOLD(128)
    ) dut2 (
        .clk_in(clk), .rst_in(rst), .start_record(start_record),
        .stop_record(stop_record), .signal_12khz(strobe), .mic_in(mic),
        .rd_addr(rd_addr), .rd_data(rdw[2]), .recording(recw[2]),
        .record_done(donew[2]), .rec_len(lenw[2])
    );

    task automatic cyc();
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            if (donew[k] === 1'b1) done_cnt[k]++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_record = 1'b0;
        stop_record = 1'b0;
        strobe = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) done_cnt[k] = 0;
    endtask

    task automatic send(input int v, input bit stp);
        strobe = 1'b1;
        mic = 8'(v);
        stop_record = stp;
        cyc();
        strobe = 1'b0;
        stop_record = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic pulse_start();
        start_record = 1'b1;
        cyc();
        start_record = 1'b0;
        cyc();
    endtask

    task automatic pulse_stop();
        stop_record = 1'b1;
        cyc();
        stop_record = 1'b0;
        cyc();
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, got, want);
        end
    endtask

    // Expected words come from exq; in-flight expectations ride sb
    task automatic readback(input int sel, input int base);
        int n;
        sample_t e;
        n = exq.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                e = sb.pop_front();
                n_cmp++;
                if (rdw[sel] !== e) begin
                    n_err++;
                    $display("FAIL readback dut%0d addr %0d: got %0d required %0d",
                             sel, base + i - 2, $signed(rdw[sel]), e);
                end
            end
            if (i < n) begin
                rd_addr = 16'(base + i);
                sb.push_back(exq.pop_front());
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset recording", int'(recw[0]), 0);
        chk("reset record_done", int'(donew[0]), 0);
        chk("reset rec_len", int'(lenw[0]), 0);
        chk("reset rd_data", int'(rdw[0]), 0);
        do_reset();
    endtask

    task automatic test_basic_fill();
        sample_t a8;
        do_reset();
        pulse_start();
        chk("fill recording after start", int'(recw[0]), 1);
        for (int i = 1; i <= 7; i++) send(i, 1'b0);
        chk("fill recording before last", int'(recw[0]), 1);
        chk("fill no early done", done_cnt[0], 0);
        strobe = 1'b1;
        mic = 8'd8;
        cyc();
        strobe = 1'b0;
        chk("fill done pulse", int'(donew[0]), 1);
        chk("fill recording low", int'(recw[0]), 0);
        cyc();
        chk("fill done one cycle", int'(donew[0]), 0);
        chk("fill rec_len", int'(lenw[0]), 8);
        send(77, 1'b0);
        send(78, 1'b0);
        chk("fill done count", done_cnt[0], 1);
        for (int i = 1; i <= 8; i++) exq.push_back(sample_t'(i));
        readback(0, 0);
        rd_addr = 16'd8;
        repeat (2) cyc();
        a8 = sample_t'(rdw[0]);
        n_cmp++;
        if (a8 === 8'sd8 || a8 === 8'sd77 || a8 === 8'sd78) begin
            n_err++;
            $display("FAIL addr8 untouched: got %0d required not 8/77/78", a8);
        end
    endtask

    task automatic test_early_stop();
        do_reset();
        pulse_start();
        send(10, 1'b0);
        send(11, 1'b0);
        strobe = 1'b1;
        mic = 8'(-5);
        stop_record = 1'b1;
        cyc();
        strobe = 1'b0;
        stop_record = 1'b0;
        chk("stop done pulse", int'(donew[0]), 1);
        repeat (4) cyc();
        chk("stop rec_len", int'(lenw[0]), 3);
        chk("stop done count", done_cnt[0], 1);
        chk("stop recording", int'(recw[0]), 0);
        exq.push_back(sample_t'(10));
        exq.push_back(sample_t'(11));
        exq.push_back(sample_t'(-5));
        readback(0, 0);
    endtask

    task automatic test_trigger();
        do_reset();
        pulse_start();
        chk("trig armed", int'(recw[1]), 1);
        send(3, 1'b0);
        send(-15, 1'b0);
        chk("trig still armed", int'(recw[1]), 1);
        send(-16, 1'b0);
        send(40, 1'b0);
        pulse_stop();
        chk("trig rec_len", int'(lenw[1]), 2);
        chk("trig done count", done_cnt[1], 1);
        exq.push_back(sample_t'(-16));
        exq.push_back(sample_t'(40));
        readback(1, 0);
        pulse_start();
        pulse_stop();
        chk("armed stop recording", int'(recw[1]), 0);
        chk("armed stop rec_len", int'(lenw[1]), 2);
        chk("armed stop no done", done_cnt[1], 1);
    endtask

    task automatic test_edge_magnitude();
        do_reset();
        pulse_start();
        send(127, 1'b0);
        send(-128, 1'b0);
        send(5, 1'b0);
        pulse_stop();
        chk("edge rec_len", int'(lenw[2]), 2);
        exq.push_back(sample_t'(-128));
        exq.push_back(sample_t'(5));
        readback(2, 0);
    endtask

    task automatic test_overlap();
        do_reset();
        pulse_start();
        send(1, 1'b0);
        send(2, 1'b0);
        pulse_start();
        send(3, 1'b0);
        send(4, 1'b0);
        pulse_stop();
        chk("overlap rec_len", int'(lenw[0]), 4);
        for (int i = 1; i <= 4; i++) exq.push_back(sample_t'(i));
        readback(0, 0);
        pulse_start();
        chk("restart recording", int'(recw[0]), 1);
        chk("restart keeps rec_len", int'(lenw[0]), 4);
        send(9, 1'b0);
        send(9, 1'b0);
        send(9, 1'b0);
        chk("restart mid rec_len", int'(lenw[0]), 4);
        pulse_stop();
        chk("restart new rec_len", int'(lenw[0]), 3);
        chk("restart done count", done_cnt[0], 2);
        start_record = 1'b1;
        stop_record = 1'b1;
        cyc();
        start_record = 1'b0;
        stop_record = 1'b0;
        cyc();
        chk("start wins over stop", int'(recw[0]), 1);
        pulse_stop();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        send(55, 1'b0);
        pulse_stop();
        chk("pre-reset rec_len", int'(lenw[0]), 1);
        pulse_start();
        for (int i = 21; i <= 24; i++) send(i, 1'b0);
        rst = 1'b1;
        cyc();
        chk("midreset recording", int'(recw[0]), 0);
        chk("midreset rec_len", int'(lenw[0]), 0);
        rst = 1'b0;
        repeat (6) cyc();
        chk("midreset no done", done_cnt[0], 1);
        for (int i = 21; i <= 24; i++) exq.push_back(sample_t'(i));
        readback(0, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) done_cnt[k] = 0;
        test_reset();
        test_basic_fill();
        test_early_stop();
        test_trigger();
        test_edge_magnitude();
        test_overlap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
